// File: rtl/ysyx_25020037_ifu_fq_pkg.sv
// Shared configuration for the IFU fetch-queue slice: FSM encodings, SDRAM
// window, IFU->IDU bus width, AXI constants and the queue entry layout.
package ysyx_25020037_ifu_fq_pkg;

    localparam int unsigned FU_TO_DU_BUS_WD = 64;

    // Region served by a burst-capable slave; everything else gets single beats.
    localparam logic [31:0] SDRAM_BASE = 32'hA000_0000;
    localparam logic [31:0] SDRAM_END  = 32'hBFFF_FFFF;

    // Refill FSM encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

    // One fetch-queue entry
    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // True when a line base may be refilled with a single INCR burst
    function automatic logic in_sdram(input logic [31:0] addr);
        return (addr >= SDRAM_BASE) && (addr <= SDRAM_END);
    endfunction

endpackage

// File: rtl/ysyx_25020037_fetch_fifo.sv
// Fetch queue storage: circular buffer with flush.
// Ports: clk, rst_n (async active-low); push/din write the tail; pop
// retires the head (dout); flush empties the queue; full/empty flags.
// A push into a full queue is accepted only alongside a pop.
module ysyx_25020037_fetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ysyx_25020037_ifu_fq.sv
// IFU front end: fetch-PC sequencing, fetch queue toward the IDU and the
// AXI4 read refill engine for the icache.
// Ports: clk/rst_n; redirect_valid/redirect_pc from EXU; idu_ready,
// ifu_valid, fu_to_du_bus {pc,inst}, access_fault toward IDU; icache_addr,
// icache_data, icache_hit, mem_req, mem_addr, mem_data, mem_ready toward the
// icache; AXI4 AR/R master channels.
// Build option: YSYX_25020037_IFU_FQ_EN selects an FQ_DEPTH-entry queue;
// without it the queue is a single entry.
module ysyx_25020037_ifu_fq
    import ysyx_25020037_ifu_fq_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned FQ_DEPTH   = 4,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       idu_ready,
    output logic                       ifu_valid,
    output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
    output logic                       access_fault,
    output logic [31:0]                icache_addr,
    input  logic [31:0]                icache_data,
    input  logic                       icache_hit,
    input  logic                       mem_req,
    input  logic [31:0]                mem_addr,
    output logic [BLOCK_SIZE*8-1:0]    mem_data,
    output logic                       mem_ready,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [31:0]                araddr,
    output logic [3:0]                 arid,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic [3:0]                 rid
);

    localparam int unsigned BEATS     = BLOCK_SIZE / 4;
    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0] LINE_MASK = ~32'(BLOCK_SIZE - 1);
`ifdef YSYX_25020037_IFU_FQ_EN
    localparam int unsigned Q_DEPTH = FQ_DEPTH;
`else
    // Single-entry queue; FQ_DEPTH stays on the interface but has no effect.
    localparam int unsigned Q_DEPTH = FQ_DEPTH - FQ_DEPTH + 1;
`endif

    logic [1:0]              state_q, state_n;
    logic [31:0]             fetch_pc_q;
    logic [31:0]             line_base_q;
    logic                    burst_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic                    fault_q;
    logic [31:0]             araddr_q;
    logic [7:0]              arlen_q;
    logic [1:0]              arburst_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    mem_ready_q;
    logic [BLOCK_SIZE*8-1:0] mem_data_q;

    logic        q_full, q_empty, q_pop;
    logic        hit_push, start_miss;
    logic        r_fire, line_end, txn_end;
    logic [31:0] miss_base;
    fq_entry_t   push_entry, head;

    assign miss_base = mem_addr & LINE_MASK;
    assign q_pop     = ~q_empty & idu_ready;

    // A full queue still accepts a hit when the head retires in the same cycle
    assign hit_push   = (state_q == S_IDLE) & icache_hit & ~redirect_valid & (~q_full | q_pop);
    // Hold off for the mem_ready cycle so the icache can install the line first
    assign start_miss = (state_q == S_IDLE) & ~icache_hit & mem_req & ~q_full
                        & ~redirect_valid & ~mem_ready_q;

    assign r_fire   = rvalid & rready_q & (rid == 4'd0);
    assign line_end = burst_q ? rlast : (beat_cnt_q == CNT_W'(BEATS - 1));
    // Each single-beat read is its own AXI transaction
    assign txn_end  = ~burst_q | rlast;

    assign push_entry.fault = fault_q & ((fetch_pc_q & LINE_MASK) == line_base_q);
    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.inst  = icache_data;

    ysyx_25020037_fetch_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (Q_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hit_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE: if (start_miss) state_n = S_AR;
            S_AR: begin
                if (redirect_valid) state_n = S_DROP;
                else if (arready)   state_n = S_R;
            end
            S_R: begin
                if (r_fire) begin
                    if (redirect_valid)  state_n = txn_end ? S_IDLE : S_DROP;
                    else if (line_end)   state_n = S_IDLE;
                    else if (!burst_q)   state_n = S_AR;
                end else if (redirect_valid) begin
                    state_n = S_DROP;
                end
            end
            S_DROP: if (r_fire && txn_end) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Fetch PC, AR channel, line assembly and fault tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            line_base_q <= '0;
            burst_q     <= 1'b0;
            beat_cnt_q  <= '0;
            fault_q     <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arburst_q   <= AXI_BURST_FIXED;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_data_q  <= '0;
        end else begin
            rready_q    <= (state_n == S_R) || (state_n == S_DROP);
            mem_ready_q <= (state_q == S_R) && r_fire && line_end && !redirect_valid;

            if (redirect_valid)  fetch_pc_q <= redirect_pc & ~32'h3;
            else if (hit_push)   fetch_pc_q <= fetch_pc_q + 32'd4;

            if (start_miss) begin
                line_base_q <= miss_base;
                burst_q     <= in_sdram(miss_base);
                araddr_q    <= miss_base;
                arlen_q     <= in_sdram(miss_base) ? 8'(BEATS - 1) : 8'd0;
                arburst_q   <= in_sdram(miss_base) ? AXI_BURST_INCR : AXI_BURST_FIXED;
                arvalid_q   <= 1'b1;
            end else if ((state_q == S_R) && (state_n == S_AR)) begin
                araddr_q  <= araddr_q + 32'd4;
                arvalid_q <= 1'b1;
            end else if (arvalid_q && arready) begin
                arvalid_q <= 1'b0;
            end

            if ((state_q == S_R) && r_fire) begin
                mem_data_q[32*beat_cnt_q +: 32] <= rdata;
                beat_cnt_q <= line_end ? '0 : beat_cnt_q + CNT_W'(1);
                if (rresp != 2'b00) fault_q <= 1'b1;
            end
            if ((state_q != S_IDLE) && (state_n == S_IDLE)) beat_cnt_q <= '0;

            if (start_miss || redirect_valid) fault_q <= 1'b0;
        end
    end

    assign ifu_valid    = ~q_empty;
    assign fu_to_du_bus = {head.pc, head.inst};
    assign access_fault = ~q_empty & head.fault;
    assign icache_addr  = fetch_pc_q;
    assign mem_data     = mem_data_q;
    assign mem_ready    = mem_ready_q;
    assign arvalid      = arvalid_q;
    assign araddr       = araddr_q;
    assign arid         = 4'd0;
    assign arlen        = arlen_q;
    assign arsize       = AXI_SIZE_4B;
    assign arburst      = arburst_q;
    assign rready       = rready_q;

endmodule

// File: doc/ysyx_25020037_ifu_fq.md
YSYX_25020037_IFU_FQ -- requirements
Module: ysyx_25020037_ifu_fq

Interface
REQ-001 SHALL provide parameter BLOCK_SIZE, default 16, icache line size in bytes (power of two, 4..16).
REQ-002 SHALL provide parameter FQ_DEPTH, default 4, fetch-queue entries (power of two, 2..8).
REQ-003 SHALL provide parameter RESET_PC, default 32'h8000_0000, first fetch address.
REQ-004 SHALL provide these ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  EXU branch/jump redirect.
- redirect_pc  in  32  redirect target.
- idu_ready  in  1  IDU accepts head entry.
- ifu_valid  out  1  head entry valid.
- fu_to_du_bus  out  64  {pc, inst} of head entry.
- access_fault  out  1  head entry fetched with rresp != OKAY.
- icache_addr  out  32  lookup address (= fetch_pc).
- icache_data  in  32  hit word.
- icache_hit  in  1  lookup hit.
- mem_req  in  1  icache requests refill.
- mem_addr  in  32  refill address.
- mem_data  out  BLOCK_SIZE*8  refill line, word i at bits [32i +: 32].
- mem_ready  out  1  one-cycle refill-complete pulse.
- arvalid/arready  out/in  1/1  AXI4 AR handshake.
- araddr, arid, arlen, arsize, arburst  out  32/4/8/3/2  AR payload (arid=0, arsize=2).
- rvalid/rready  in/out  1/1  AXI4 R handshake.
- rdata, rresp, rlast, rid  in  32/2/1/4  R payload.

Function
REQ-005 SHALL implement FSM IDLE, AR, R, DROP; transitions: IDLE->AR on miss with mem_req and queue not full; AR->R on arvalid&arready; R->IDLE after the last beat of the line; AR/R->DROP on redirect_valid; DROP->IDLE after the outstanding last beat.
REQ-006 In IDLE with queue not full and no redirect, a hit SHALL push {fetch_pc, icache_data} and set fetch_pc += 4 in the same cycle (1 instruction/cycle throughput).
REQ-007 When the line base (mem_addr with low log2(BLOCK_SIZE) bits zero) has [31:28] equal to 4'hA or 4'hB, the block SHALL issue one INCR burst with arburst=1 and arlen=BLOCK_SIZE/4-1, and SHALL end the line on rlast.
REQ-008 For all other addresses the block SHALL issue BLOCK_SIZE/4 sequential single beats (arlen=0, arburst=0) at base+4k, returning R->AR between beats.
REQ-009 arvalid and the AR payload SHALL stay stable until arready; rready SHALL be 1 throughout R and DROP.
REQ-010 mem_ready SHALL pulse exactly one cycle after the final beat; the beat counter SHALL wrap to 0 there.
REQ-011 Any beat with rresp != 0 SHALL set a line-fault flag; hits on a faulted line SHALL push entries with the fault bit set, and access_fault SHALL reflect the head entry.
REQ-012 ifu_valid SHALL equal queue non-empty; the head SHALL pop on ifu_valid & idu_ready; a push into a full queue SHALL be allowed only with a same-cycle pop.
REQ-013 redirect_valid SHALL empty the queue, load fetch_pc with redirect_pc, and discard any same-cycle push, all in that cycle.
REQ-014 A redirect before arready SHALL keep arvalid asserted until accepted, then drain; in DROP all beats SHALL be consumed, with mem_ready and the fault flag suppressed.
REQ-015 redirect_pc SHALL be treated as word aligned; bits [1:0] are ignored.

Reset
REQ-016 While rst_n=0: FSM=IDLE, fetch_pc=RESET_PC, queue empty, and ifu_valid, arvalid, rready, mem_ready, access_fault, beat counter and fault flag all 0. Reset mid-burst abandons the transaction.

Configuration
REQ-017 With YSYX_25020037_IFU_FQ_EN defined the queue SHALL hold FQ_DEPTH entries; when undefined it SHALL be a single entry, and fetch SHALL resume only once that entry pops (FQ_DEPTH ignored).

Structure
REQ-018 FSM encodings, SDRAM_BASE/SDRAM_END and the FU_TO_DU_BUS_WD width SHALL live in the shared config include.
REQ-019 The queue SHALL be the sub-module ysyx_25020037_fetch_fifo (parameters width and depth; push, pop, flush, full, empty).

Verification
REQ-020 Reset, all hits, idu_ready=1: fu_to_du_bus pc sequence 80000000, 80000004, 80000008 on consecutive cycles.
REQ-021 Miss at A0000010, BLOCK_SIZE=16: one AR with araddr=A0000010, arlen=3, arburst=1; after 4 beats, mem_ready for 1 cycle with words in order.
REQ-022 Miss at 80000020: 4 ARs at 80000020/24/28/2C, each with arlen=0.
REQ-023 Redirect to 80000100 during beat 2 of a burst: remaining beats drained, no mem_ready, next AR or lookup at 80000100.
REQ-024 idu_ready=0 for 10 cycles: exactly FQ_DEPTH pushes, then a stall; with the macro undefined, exactly 1 push.
REQ-025 rresp=2 on one beat: entries from that line have access_fault=1, and a redirect clears it.
